// File: rtl/avalon_sram_ctrl.sv
// Avalon-MM responder that serves 32-bit dbus requests from a 16-bit asynchronous SRAM.
// Optional build macro SRAM_SKIP_UNUSED_HALF_EN skips halfword phases whose byte enables are all zero.

package avalon_sram_ctrl_pkg;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [3:0]  byte_enable;
  } avalon_req_t;

  typedef struct packed {
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        waitrequest;
  } avalon_resp_t;

endpackage

module avalon_sram_ctrl
  import avalon_sram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  avalon_req_t       dbus_avalon_req,
  output avalon_resp_t      dbus_avalon_resp,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_write,
  input  logic [15:0]       sram_dq_read,
  output logic              sram_dq_en,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               last_cyc;
  logic               req_vld;
  logic [1:0]         half_be;

  logic [ADDR_W-2:0]  addr_p0;
  logic [31:0]        wdata_p0;
  logic [3:0]         be_p0;
  logic               wr_p0;
  logic [31:0]        data_p0;

  logic [31:0]        readdata_p1;
  logic               vld_p1;

  logic               unused_addr;

  // Keeps only the bytes that were actually selected; deselected lanes float on the pads.
  function automatic logic [15:0] lane_mask(input logic [15:0] dq, input logic [1:0] be);
    return {be[1] ? dq[15:8] : 8'h00, be[0] ? dq[7:0] : 8'h00};
  endfunction

  function automatic state_t first_phase(input logic [3:0] be);
`ifdef SRAM_SKIP_UNUSED_HALF_EN
    if (be[1:0] != 2'b00)      return LO;
    else if (be[3:2] != 2'b00) return HI;
    else                       return DONE;
`else
    return (be != 4'b0000) ? LO : DONE;
`endif
  endfunction

  function automatic state_t after_lo(input logic [3:0] be);
`ifdef SRAM_SKIP_UNUSED_HALF_EN
    return (be[3:2] != 2'b00) ? HI : DONE;
`else
    return (be != 4'b0000) ? HI : DONE;
`endif
  endfunction

  assign req_vld     = dbus_avalon_req.read | dbus_avalon_req.write;
  assign last_cyc    = (cnt == CNT_LAST);
  assign half_be     = (state == HI) ? be_p0[3:2] : be_p0[1:0];
  assign unused_addr = ^{dbus_avalon_req.address[31:ADDR_W+1], dbus_avalon_req.address[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        cnt <= '0;
      else if (state == LO || state == HI)
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_vld) state_nxt = first_phase(dbus_avalon_req.byte_enable);
      LO:      if (last_cyc) state_nxt = after_lo(be_p0);
      HI:      if (last_cyc) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sram_addr     = '0;
    sram_dq_write = '0;
    sram_dq_en    = 1'b0;
    sram_ce_n     = 1'b1;
    sram_oe_n     = 1'b1;
    sram_we_n     = 1'b1;
    sram_ub_n     = 1'b1;
    sram_lb_n     = 1'b1;
    dbus_avalon_resp.readdata      = readdata_p1;
    dbus_avalon_resp.readdatavalid = vld_p1;
    dbus_avalon_resp.waitrequest   = (state != DONE);
    if (state == LO || state == HI) begin
      sram_addr = {addr_p0, state == HI};
      sram_ce_n = 1'b0;
      sram_ub_n = ~half_be[1];
      sram_lb_n = ~half_be[0];
      if (wr_p0) begin
        // we_n rises on the last phase cycle so data is held past the write strobe.
        sram_dq_en    = 1'b1;
        sram_dq_write = (state == HI) ? wdata_p0[31:16] : wdata_p0[15:0];
        sram_we_n     = last_cyc;
      end else begin
        sram_oe_n = 1'b0;
      end
    end
  end

  // Stage p0: request latched in IDLE, read halfwords assembled at the end of each phase.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_vld) begin
      addr_p0  <= dbus_avalon_req.address[ADDR_W:2];
      wdata_p0 <= dbus_avalon_req.writedata;
      be_p0    <= dbus_avalon_req.byte_enable;
      wr_p0    <= dbus_avalon_req.write;
      data_p0  <= '0;
    end
    if (state == LO && last_cyc && !wr_p0)
      data_p0[15:0] <= lane_mask(sram_dq_read, be_p0[1:0]);
    if (state == HI && last_cyc && !wr_p0)
      data_p0[31:16] <= lane_mask(sram_dq_read, be_p0[3:2]);
  end

  // Stage p1: read response, one cycle after the DONE handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      readdata_p1 <= '0;
    end else begin
      vld_p1 <= (state == DONE) && !wr_p0;
      if (state == DONE && !wr_p0)
        readdata_p1 <= data_p0;
    end
  end

endmodule

// File: tb/tb_avalon_sram_ctrl.sv
// Scoreboard bench for avalon_sram_ctrl: word-level reference memory, SRAM pin model, random traffic.
module tb_avalon_sram_ctrl;
  import avalon_sram_ctrl_pkg::*;

  localparam int ADDR_W      = 18;
  localparam int WAIT_CYCLES = 2;
  localparam int PH          = WAIT_CYCLES + 1;

  logic              clk = 1'b0;
  logic              rst;
  avalon_req_t       req;
  avalon_resp_t      resp;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_dq_write;
  logic [15:0]       sram_dq_read;
  logic              sram_dq_en, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  logic [15:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] ref_mem [0:15];
  logic [31:0] exp_q [$];

  int checks = 0;
  int errors = 0;
  int ce_cnt, we_cnt, dqen_cnt, oe_cnt;
  logic prev_wl = 1'b0;

  avalon_sram_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .dbus_avalon_req(req), .dbus_avalon_resp(resp),
    .sram_addr(sram_addr), .sram_dq_write(sram_dq_write), .sram_dq_read(sram_dq_read),
    .sram_dq_en(sram_dq_en), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  always #5 clk = ~clk;

  // Deselected lanes return garbage to mimic floating pads.
  always_comb begin
    sram_dq_read = 16'hEEEE;
    if (!sram_ce_n && !sram_oe_n) begin
      if (!sram_lb_n) sram_dq_read[7:0]  = mem[sram_addr][7:0];
      if (!sram_ub_n) sram_dq_read[15:8] = mem[sram_addr][15:8];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic int nphases(input logic [3:0] be);
`ifdef SRAM_SKIP_UNUSED_HALF_EN
    return ((be[1:0] != 2'b00) ? 1 : 0) + ((be[3:2] != 2'b00) ? 1 : 0);
`else
    return (be != 4'b0000) ? 2 : 0;
`endif
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Monitor: SRAM pin model, pin activity counters and response scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      prev_wl = 1'b0;
    end else begin
      if (!sram_ce_n && !sram_we_n) begin
        if (!sram_lb_n) mem[sram_addr][7:0]  = sram_dq_write[7:0];
        if (!sram_ub_n) mem[sram_addr][15:8] = sram_dq_write[15:8];
      end
      if (!sram_ce_n) ce_cnt++;
      if (!sram_we_n) we_cnt++;
      if (sram_dq_en) dqen_cnt++;
      if (!sram_oe_n) oe_cnt++;
      if (resp.readdatavalid) begin
        check("RDV_AFTER_DONE", 32'(prev_wl), 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL RDV_UNEXPECTED actual=readdatavalid readdata=0x%08h expected=no response", resp.readdata);
        end else begin
          check("RDATA", resp.readdata, exp_q.pop_front());
        end
      end
      prev_wl = !resp.waitrequest;
    end
  end

  task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
    int cyc;
    int nph;
    logic [3:0] w;
    w   = addr[5:2];
    nph = nphases(be);
    if (wr)      ref_mem[w] = (ref_mem[w] & ~be_mask(be)) | (wdata & be_mask(be));
    else if (rd) exp_q.push_back(ref_mem[w] & be_mask(be));
    @(negedge clk);
    req.read        = rd;
    req.write       = wr;
    req.address     = addr;
    req.writedata   = wdata;
    req.byte_enable = be;
    ce_cnt = 0; we_cnt = 0; dqen_cnt = 0; oe_cnt = 0;
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (resp.waitrequest && cyc < 60);
    check("WAIT_LAT", 32'(cyc), 32'(nph * PH + 1));
    check("CE_CYCLES", 32'(ce_cnt), 32'(nph * PH));
    check("WE_CYCLES", 32'(we_cnt), wr ? 32'(nph * WAIT_CYCLES) : 32'd0);
    check("DQEN_CYCLES", 32'(dqen_cnt), wr ? 32'(nph * PH) : 32'd0);
    check("OE_CYCLES", 32'(oe_cnt), wr ? 32'd0 : 32'(nph * PH));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req = '0;
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i]   = $urandom;
      mem[2*i]     = ref_mem[i][15:0];
      mem[2*i+1]   = ref_mem[i][31:16];
    end
    ref_mem[8] = 32'h12345678;
    mem[16]    = 16'h5678;
    mem[17]    = 16'h1234;

    repeat (3) @(negedge clk);
    check("RST_WAITREQ", 32'(resp.waitrequest), 32'd1);
    check("RST_RDV", 32'(resp.readdatavalid), 32'd0);
    check("RST_RDATA", resp.readdata, 32'd0);
    check("RST_N_PINS", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1F);
    check("RST_DQ_EN", 32'(sram_dq_en), 32'd0);
    check("RST_ADDR", 32'(sram_addr), 32'd0);
    check("RST_DQ_WRITE", 32'(sram_dq_write), 32'd0);
    rst = 1'b0;

    do_req(1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
    do_req(1'b0, 1'b1, 32'h24, 32'hCAFEBABE, 4'hF);
    check("SW_LO_HALF", 32'(mem[18]), 32'h0000BABE);
    check("SW_HI_HALF", 32'(mem[19]), 32'h0000CAFE);
    do_req(1'b0, 1'b1, 32'h27, 32'hAB000000, 4'b1000);
    check("SB_HI_HALF", 32'(mem[19]), 32'h0000ABFE);
    check("SB_LO_HALF", 32'(mem[18]), 32'h0000BABE);

    ref_mem[8] = 32'h12349A00;
    mem[16]    = 16'h9A00;
    do_req(1'b1, 1'b0, 32'h21, 32'h0, 4'b0010);

    do_req(1'b1, 1'b1, 32'h28, 32'h0BADF00D, 4'hF);
    do_req(1'b1, 1'b0, 32'h28, 32'h0, 4'hF);
    idle(2);

    @(negedge clk);
    req.read = 1'b0; req.write = 1'b1; req.address = 32'h0C;
    req.writedata = 32'h11112222; req.byte_enable = 4'hF;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("ARST_WE_N", 32'(sram_we_n), 32'd1);
    check("ARST_CE_N", 32'(sram_ce_n), 32'd1);
    check("ARST_DQ_EN", 32'(sram_dq_en), 32'd0);
    check("ARST_WAITREQ", 32'(resp.waitrequest), 32'd1);
    check("ARST_RDATA", resp.readdata, 32'd0);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    do_req(1'b0, 1'b1, 32'h0C, 32'h33334444, 4'hF);
    do_req(1'b1, 1'b0, 32'h0C, 32'h0, 4'hF);

    for (int n = 0; n < 200; n++) begin
      int unsigned op;
      logic [31:0] a;
      op = $urandom_range(0, 3);
      a  = ({$urandom} << 19) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      do_req(op != 2, op >= 2, a, $urandom, 4'($urandom));
      idle($urandom_range(0, 2));
    end

    idle(4);
    check("EXP_Q_EMPTY", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
